// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// default geometry / reset address.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int PC_W_DEFAULT     = 8;
  localparam int INSTR_W_DEFAULT  = 16;
  localparam int RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port and decode-side instruction port of the fetch stage.
interface fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack
// and hands instructions to decode over valid/ready, with branch redirect.
//
//   state | meaning
//   IDLE  | one cycle after reset, no request outstanding
//   FETCH | request at pc outstanding
//   HOLD  | instruction registered, waiting for decode
//   DRAIN | wrong-path request still outstanding; pc holds the redirect target
import fetch_pkg::*;

module fetch_unit #(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            change_pc,
  input  logic [PC_W-1:0] branch_target,
  fetch_unit_if.master    bus
);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    req_addr_q;
  logic [INSTR_W-1:0] instr_out_q;
  logic [PC_W-1:0]    instr_pc_q;
  logic               instr_valid_q;
  logic               redirect;

  assign redirect = ex_valid & change_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack && !redirect) state_d = HOLD;
        else if (!bus.imem_ack && redirect) state_d = DRAIN;
      end
      DRAIN: if (bus.imem_ack) state_d = FETCH;
      HOLD:  if (bus.instr_ready || redirect) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    bus.imem_addr   = (state_q == DRAIN) ? req_addr_q : pc_q;
    bus.instr_valid = instr_valid_q;
    bus.instr_out   = instr_out_q;
    bus.instr_pc    = instr_pc_q;
  end

  // In DRAIN pc already holds the redirect target; req_addr_q keeps the
  // address of the request that memory has not yet acknowledged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (redirect) pc_q <= branch_target;
        FETCH: begin
          req_addr_q <= pc_q;
          if (redirect) begin
            pc_q <= branch_target;
          end else if (bus.imem_ack) begin
            pc_q          <= pc_q + PC_W'(1);
            instr_out_q   <= bus.imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
          end
        end
        DRAIN: if (redirect) pc_q <= branch_target;
        HOLD: begin
          if (redirect) pc_q <= branch_target;
          if (bus.instr_ready || redirect) instr_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
